// File: rtl/dmem_access.sv
// dmem_access: data-memory access stage sitting right after exe.
// Takes one combinational load/store request from exe and runs it as a single
// transaction on a req/gnt/rvalid bus. The stage builds the byte enables and
// store-lane alignment, and it extracts and sign/zero-extends load data.
// exe is held through stall_o until the bus response arrives.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   adr_v_i .. unsign_extension_i
//                         request from exe (valid, byte address, store flag,
//                         right-aligned store data, one-hot size, zero-extend)
//   stall_o               hold exe/dec while a transaction is outstanding
//   load_v_o/load_data_o  extended load result, valid for the completion cycle
//   misalign_o            misaligned request dropped (1-cycle pulse)
//   bus_err_o             bus error response (1-cycle pulse)
//   dmem_*_o / dmem_*_i   data bus master side
module dmem_access #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adr_v_i,
  input  logic [XLEN-1:0]   adr_i,
  input  logic              is_store_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [2:0]        access_size_i,
  input  logic              unsign_extension_i,
  output logic              stall_o,
  output logic              load_v_o,
  output logic [XLEN-1:0]   load_data_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_adr_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  input  logic              dmem_err_i
);

  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state_reg;
  logic [XLEN-1:0] adr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [NB-1:0]   be_reg;
  logic            we_reg;
  logic            is_byte_reg;
  logic            is_half_reg;
  logic            unsign_reg;
  logic [1:0]      off_reg;

  // Size decode. The lowest set bit wins. A request with no size bit set fails
  // every alignment test, so it is dropped as misaligned and never reaches the bus.
  logic is_byte, is_half, is_word, aligned;
  assign is_byte = access_size_i[0];
  assign is_half = access_size_i[1] & ~access_size_i[0];
  assign is_word = access_size_i[2] & ~access_size_i[1] & ~access_size_i[0];
  assign aligned = is_byte
                 | (is_half & ~adr_i[0])
                 | (is_word & (adr_i[1:0] == 2'b00));

  logic accept;
  assign accept     = (state_reg == IDLE) & adr_v_i & aligned;
  assign misalign_o = (state_reg == IDLE) & adr_v_i & ~aligned;

  // Byte enables and lane-replicated store data for the incoming request.
  logic [NB-1:0]   be_next;
  logic [XLEN-1:0] wdata_next;
  logic [XLEN-1:0] adr_next;

  assign be_next  = is_byte ? (NB'(1) << adr_i[1:0]) :
                    is_half ? (NB'(3) << adr_i[1:0]) : {NB{1'b1}};
  assign adr_next = {adr_i[XLEN-1:2], 2'b00};

  // Replicating the store data into every lane means the enabled lane always
  // holds the right bytes, whatever the offset.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign wdata_next[8*gi +: 8] = is_byte ? store_data_i[7:0] :
                                   is_half ? store_data_i[8*(gi%2) +: 8] :
                                             store_data_i[8*gi +: 8];
  end

  // Completion: the bus response that finishes the outstanding transaction.
  // rvalid in REQ counts only when it arrives together with gnt.
  logic done;
  assign done = ((state_reg == REQ) & dmem_gnt_i & dmem_rvalid_i)
              | ((state_reg == WAIT) & dmem_rvalid_i);

  // The stall drops in the completion cycle so exe advances on that same edge.
  assign stall_o = accept
                 | ((state_reg == REQ)  & ~(dmem_gnt_i & dmem_rvalid_i))
                 | ((state_reg == WAIT) & ~dmem_rvalid_i);

  assign dmem_req_o   = (state_reg == REQ);
  assign dmem_we_o    = we_reg;
  assign dmem_adr_o   = adr_reg;
  assign dmem_be_o    = be_reg;
  assign dmem_wdata_o = wdata_reg;

  // Load extraction: shift the addressed field down, then extend it.
  // A word access is always at offset 0, so it passes through unchanged.
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] extended;
  assign shifted = dmem_rdata_i >> {off_reg, 3'b000};

  always_comb begin
    extended = shifted;
    if (is_byte_reg)
      extended = {{(XLEN-8){~unsign_reg & shifted[7]}}, shifted[7:0]};
    else if (is_half_reg)
      extended = {{(XLEN-16){~unsign_reg & shifted[15]}}, shifted[15:0]};
  end

  assign load_v_o    = done & ~we_reg & ~dmem_err_i;
  assign bus_err_o   = done & dmem_err_i;
  assign load_data_o = load_v_o ? extended : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      adr_reg     <= '0;
      wdata_reg   <= '0;
      be_reg      <= '0;
      we_reg      <= 1'b0;
      is_byte_reg <= 1'b0;
      is_half_reg <= 1'b0;
      unsign_reg  <= 1'b0;
      off_reg     <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            adr_reg     <= adr_next;
            wdata_reg   <= wdata_next;
            be_reg      <= be_next;
            we_reg      <= is_store_i;
            is_byte_reg <= is_byte;
            is_half_reg <= is_half;
            unsign_reg  <= unsign_extension_i;
            off_reg     <= adr_i[1:0];
            state_reg   <= REQ;
          end
        end
        REQ: begin
          if (dmem_gnt_i)
            state_reg <= dmem_rvalid_i ? IDLE : WAIT;
        end
        WAIT: begin
          if (dmem_rvalid_i)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: directed test of dmem_access with hand-computed expectations.
// Inputs change just after the falling edge. Outputs are sampled 1 ns later,
// which keeps every sample away from the rising edge.
module tb_dmem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        adr_v_i;
  logic [31:0] adr_i;
  logic        is_store_i;
  logic [31:0] store_data_i;
  logic [2:0]  access_size_i;
  logic        unsign_extension_i;
  logic        stall_o, load_v_o, misalign_o, bus_err_o;
  logic [31:0] load_data_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_adr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i, dmem_err_i;
  logic [31:0] dmem_rdata_i;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] SZ_B = 3'b001;
  localparam logic [2:0] SZ_H = 3'b010;
  localparam logic [2:0] SZ_W = 3'b100;

  always #5 clk = ~clk;

  dmem_access #(.XLEN(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .adr_v_i            (adr_v_i),
    .adr_i              (adr_i),
    .is_store_i         (is_store_i),
    .store_data_i       (store_data_i),
    .access_size_i      (access_size_i),
    .unsign_extension_i (unsign_extension_i),
    .stall_o            (stall_o),
    .load_v_o           (load_v_o),
    .load_data_o        (load_data_o),
    .misalign_o         (misalign_o),
    .bus_err_o          (bus_err_o),
    .dmem_req_o         (dmem_req_o),
    .dmem_we_o          (dmem_we_o),
    .dmem_adr_o         (dmem_adr_o),
    .dmem_be_o          (dmem_be_o),
    .dmem_wdata_o       (dmem_wdata_o),
    .dmem_gnt_i         (dmem_gnt_i),
    .dmem_rvalid_i      (dmem_rvalid_i),
    .dmem_rdata_i       (dmem_rdata_i),
    .dmem_err_i         (dmem_err_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic v, input logic [31:0] a, input logic st,
                           input logic [31:0] d, input logic [2:0] sz, input logic u);
    adr_v_i            = v;
    adr_i              = a;
    is_store_i         = st;
    store_data_i       = d;
    access_size_i      = sz;
    unsign_extension_i = u;
  endtask

  task automatic drive_bus(input logic g, input logic rv, input logic [31:0] rd, input logic e);
    dmem_gnt_i    = g;
    dmem_rvalid_i = rv;
    dmem_rdata_i  = rd;
    dmem_err_i    = e;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // One load with gnt and rvalid in the request cycle, then an idle check.
  task automatic load_same_cycle(input string tag, input logic [31:0] a, input logic [2:0] sz,
                                 input logic u, input logic [31:0] rd,
                                 input logic [3:0] be_exp, input logic [31:0] data_exp);
    cyc(); drive_req(1'b1, a, 1'b0, 32'h0, sz, u); drive_bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk({tag, " stall accept"}, stall_o, 1);
    cyc(); drive_bus(1'b1, 1'b1, rd, 1'b0); #1;
    chk({tag, " be"}, dmem_be_o, be_exp);
    chk({tag, " we"}, dmem_we_o, 0);
    chk({tag, " load_v"}, load_v_o, 1);
    chk({tag, " load_data"}, load_data_o, data_exp);
    chk({tag, " stall done"}, stall_o, 0);
    cyc(); drive_req(1'b0, 32'h0, 1'b0, 32'h0, SZ_W, 1'b0); drive_bus(1'b0, 1'b0, rd, 1'b0); #1;
    chk({tag, " load_v after"}, load_v_o, 0);
    chk({tag, " load_data after"}, load_data_o, 0);
    $display("txn %s adr=0x%08h data=0x%08h", tag, a, data_exp);
  endtask

  initial begin
    reset = 1'b1;
    drive_req(1'b0, 32'h0, 1'b0, 32'h0, SZ_W, 1'b0);
    drive_bus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) cyc();
    reset = 1'b0; #1;
    chk("rst stall", stall_o, 0);
    chk("rst req", dmem_req_o, 0);
    chk("rst we", dmem_we_o, 0);
    chk("rst adr", dmem_adr_o, 0);
    chk("rst be", dmem_be_o, 0);
    chk("rst wdata", dmem_wdata_o, 0);
    chk("rst load_v", load_v_o, 0);
    chk("rst load_data", load_data_o, 0);
    chk("rst misalign", misalign_o, 0);
    chk("rst bus_err", bus_err_o, 0);

    // 1: SW 0x100, gnt+rvalid together with req.
    cyc(); drive_req(1'b1, 32'h100, 1'b1, 32'hDEADBEEF, SZ_W, 1'b0); #1;
    chk("t1 stall accept", stall_o, 1);
    chk("t1 req accept", dmem_req_o, 0);
    cyc(); drive_bus(1'b1, 1'b1, 32'h0, 1'b0); #1;
    chk("t1 req", dmem_req_o, 1);
    chk("t1 be", dmem_be_o, 4'b1111);
    chk("t1 wdata", dmem_wdata_o, 32'hDEADBEEF);
    chk("t1 we", dmem_we_o, 1);
    chk("t1 adr", dmem_adr_o, 32'h100);
    chk("t1 stall done", stall_o, 0);
    chk("t1 load_v", load_v_o, 0);
    chk("t1 bus_err", bus_err_o, 0);
    cyc(); drive_req(1'b0, 32'h0, 1'b0, 32'h0, SZ_W, 1'b0); drive_bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("t1 req after", dmem_req_o, 0);
    chk("t1 stall after", stall_o, 0);
    $display("txn SW adr=0x100 data=0xdeadbeef");

    // 2: SB 0x103, gnt then rvalid one cycle later.
    cyc(); drive_req(1'b1, 32'h103, 1'b1, 32'h000000AB, SZ_B, 1'b0); #1;
    chk("t2 stall accept", stall_o, 1);
    cyc(); drive_bus(1'b1, 1'b0, 32'h0, 1'b0); #1;
    chk("t2 be", dmem_be_o, 4'b1000);
    chk("t2 wdata", dmem_wdata_o, 32'hABABABAB);
    chk("t2 adr", dmem_adr_o, 32'h100);
    chk("t2 stall req", stall_o, 1);
    cyc(); drive_bus(1'b0, 1'b1, 32'h0, 1'b0); #1;
    chk("t2 req wait", dmem_req_o, 0);
    chk("t2 stall done", stall_o, 0);
    chk("t2 load_v", load_v_o, 0);
    cyc(); drive_req(1'b0, 32'h0, 1'b0, 32'h0, SZ_W, 1'b0); drive_bus(1'b0, 1'b0, 32'h0, 1'b0);
    $display("txn SB adr=0x103 data=0xab");

    // 3: LH at 0x102, signed then unsigned.
    load_same_cycle("t3 LH", 32'h102, SZ_H, 1'b0, 32'h80011234, 4'b1100, 32'hFFFF8001);
    load_same_cycle("t3 LHU", 32'h102, SZ_H, 1'b1, 32'h80011234, 4'b1100, 32'h00008001);
    load_same_cycle("t3 LB", 32'h101, SZ_B, 1'b0, 32'h00008000, 4'b0010, 32'hFFFFFF80);

    // 4: LW 0x200, gnt after 3 cycles, rvalid 2 cycles after gnt.
    // A stray rvalid before gnt must be ignored.
    cyc(); drive_req(1'b1, 32'h200, 1'b0, 32'h0, SZ_W, 1'b0); #1;
    chk("t4 stall accept", stall_o, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); drive_bus(i == 3, i == 1, 32'hCAFEF00D, 1'b0); #1;
      chk($sformatf("t4 req c%0d", i), dmem_req_o, 1);
      chk($sformatf("t4 adr c%0d", i), dmem_adr_o, 32'h200);
      chk($sformatf("t4 stall c%0d", i), stall_o, 1);
      chk($sformatf("t4 load_v c%0d", i), load_v_o, 0);
    end
    cyc(); drive_bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("t4 req wait", dmem_req_o, 0);
    chk("t4 stall wait", stall_o, 1);
    cyc(); drive_bus(1'b0, 1'b1, 32'h12345678, 1'b0); #1;
    chk("t4 stall done", stall_o, 0);
    chk("t4 load_v", load_v_o, 1);
    chk("t4 load_data", load_data_o, 32'h12345678);
    cyc(); drive_req(1'b0, 32'h0, 1'b0, 32'h0, SZ_W, 1'b0); drive_bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("t4 load_v after", load_v_o, 0);
    $display("txn LW adr=0x200 data=0x12345678");

    // 5: misaligned LW 0x101.
    cyc(); drive_req(1'b1, 32'h101, 1'b0, 32'h0, SZ_W, 1'b0); #1;
    chk("t5 misalign", misalign_o, 1);
    chk("t5 stall", stall_o, 0);
    chk("t5 req", dmem_req_o, 0);
    cyc(); drive_req(1'b0, 32'h0, 1'b0, 32'h0, SZ_W, 1'b0); #1;
    chk("t5 req after", dmem_req_o, 0);
    chk("t5 misalign after", misalign_o, 0);
    $display("txn LW adr=0x101 misaligned");

    // 6a: reset while in WAIT, then a late rvalid.
    cyc(); drive_req(1'b1, 32'h300, 1'b0, 32'h0, SZ_W, 1'b0); #1;
    cyc(); drive_bus(1'b1, 1'b0, 32'h0, 1'b0); #1;
    chk("t6 stall req", stall_o, 1);
    cyc(); drive_bus(1'b0, 1'b0, 32'h0, 1'b0); reset = 1'b1; #1;
    chk("t6 stall wait", stall_o, 1);
    cyc(); reset = 1'b0; drive_req(1'b0, 32'h0, 1'b0, 32'h0, SZ_W, 1'b0);
    drive_bus(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0); #1;
    chk("t6 late load_v", load_v_o, 0);
    chk("t6 late load_data", load_data_o, 0);
    chk("t6 late stall", stall_o, 0);
    chk("t6 late req", dmem_req_o, 0);
    chk("t6 late adr", dmem_adr_o, 0);
    chk("t6 late be", dmem_be_o, 0);
    $display("txn LW adr=0x300 abandoned by reset");

    // 6b: LB with bus error.
    cyc(); drive_req(1'b1, 32'h105, 1'b0, 32'h0, SZ_B, 1'b0); drive_bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    cyc(); drive_bus(1'b1, 1'b1, 32'h0000FF00, 1'b1); #1;
    chk("t6 err be", dmem_be_o, 4'b0010);
    chk("t6 bus_err", bus_err_o, 1);
    chk("t6 err load_v", load_v_o, 0);
    chk("t6 err load_data", load_data_o, 0);
    cyc(); drive_req(1'b0, 32'h0, 1'b0, 32'h0, SZ_W, 1'b0); drive_bus(1'b1, 1'b0, 32'h0, 1'b0); #1;
    chk("t6 bus_err after", bus_err_o, 0);
    // gnt while IDLE must not start a request.
    cyc(); drive_bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("t6 idle gnt req", dmem_req_o, 0);
    $display("txn LB adr=0x105 bus error");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
